// File: rtl/rcu.sv
// USB receive control unit.
// Walks SYNC / PID / body / EOP for token, data and handshake packets using the
// byte and end-of-packet strobes from the bit-level front end. Decoded fields are
// captured into shadow registers while the packet streams in and are published,
// with a one-cycle valid pulse, only once the EOP and the CRC verdict are known.
// Malformed packets raise the sticky rcv_error flag instead.
module rcu #(
    parameter logic [7:0] SYNC_BYTE  = 8'h80,
    parameter logic [7:0] TOKEN_PID  = 8'h1E,
    parameter logic [7:0] DATA_PID   = 8'h3C,
    parameter logic [7:0] ACK_PID    = 8'h2D,
    parameter int         DATA_BYTES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    d_edge,
    input  logic                    byte_received,
    input  logic [7:0]              rcv_byte,
    input  logic                    eop,
    input  logic                    crc5_ok,
    input  logic                    crc16_ok,
    output logic                    crc_clear,
    output logic                    rcving,
    output logic                    token_valid,
    output logic [6:0]              token_addr,
    output logic [3:0]              token_endp,
    output logic                    data_valid,
    output logic [8*DATA_BYTES-1:0] rx_data,
    output logic                    ack_valid,
    output logic                    rcv_error
);

    // Body byte counter must reach DATA_BYTES+1 (last CRC16 byte).
    localparam int                CNT_W    = $clog2(DATA_BYTES + 2);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_BYTES + 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_TOK1,
        ST_TOK2,
        ST_DATA,
        ST_HS,
        ST_WAIT_EOP,
        ST_ERR
    } state_e;

    // Which body was walked before reaching WAIT_EOP; ACK never gets there.
    typedef enum logic {
        PKT_TOKEN,
        PKT_DATA
    } pkt_e;

    // Control state
    state_e     state_q, state_d;
    pkt_e       pkt_q, pkt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       tok_seen_q, tok_seen_d;

    // Registered outputs
    logic                    crc_clear_q, crc_clear_d;
    logic                    rcving_q, rcving_d;
    logic                    token_valid_q, token_valid_d;
    logic [6:0]              token_addr_q, token_addr_d;
    logic [3:0]              token_endp_q, token_endp_d;
    logic                    data_valid_q, data_valid_d;
    logic [8*DATA_BYTES-1:0] rx_data_q, rx_data_d;
    logic                    ack_valid_q, ack_valid_d;
    logic                    rcv_error_q, rcv_error_d;

    // Shadow capture registers, published only on a good EOP
    logic [6:0]              sh_addr_q, sh_addr_d;
    logic [3:0]              sh_endp_q, sh_endp_d;
    logic [8*DATA_BYTES-1:0] payload_q, payload_d;

    // Outcome helpers for the current cycle
    logic abort_pkt;  // malformed packet already ended by eop: flag it and go idle
    logic enter_err;  // malformed packet still on the wire: park in ERR until eop

    // Next-state, shadow capture and result publication
    always_comb begin
        // NOTE: every _d starts from its _q (pulses from 0) so no branch below leaves a signal unassigned and infers a latch.
        state_d       = state_q;
        pkt_d         = pkt_q;
        cnt_d         = cnt_q;
        tok_seen_d    = tok_seen_q;
        crc_clear_d   = 1'b0;
        rcving_d      = rcving_q;
        token_valid_d = 1'b0;
        token_addr_d  = token_addr_q;
        token_endp_d  = token_endp_q;
        data_valid_d  = 1'b0;
        rx_data_d     = rx_data_q;
        ack_valid_d   = 1'b0;
        rcv_error_d   = rcv_error_q;
        sh_addr_d     = sh_addr_q;
        sh_endp_d     = sh_endp_q;
        payload_d     = payload_q;
        abort_pkt     = 1'b0;
        enter_err     = 1'b0;

        // eop is checked before byte_received everywhere: a coincident byte is dropped.
        unique case (state_q)
            ST_IDLE: begin
                if (d_edge) begin
                    state_d     = ST_SYNC;
                    rcving_d    = 1'b1;
                    rcv_error_d = 1'b0;
                end
            end

            ST_SYNC: begin
                if (eop) begin
                    abort_pkt = 1'b1;
                end else if (byte_received) begin
                    if (rcv_byte == SYNC_BYTE) state_d = ST_PID;
                    else                       enter_err = 1'b1;
                end
            end

            ST_PID: begin
                if (eop) begin
                    abort_pkt = 1'b1;
                end else if (byte_received) begin
                    crc_clear_d = 1'b1;
                    if (rcv_byte == TOKEN_PID) begin
                        state_d = ST_TOK1;
                        pkt_d   = PKT_TOKEN;
                    end else if (rcv_byte == DATA_PID) begin
                        state_d = ST_DATA;
                        pkt_d   = PKT_DATA;
                        cnt_d   = '0;
                    end else if (rcv_byte == ACK_PID) begin
                        state_d = ST_HS;
                    end else begin
                        enter_err = 1'b1;
                    end
                end
            end

            ST_TOK1: begin
                if (eop) begin
                    abort_pkt = 1'b1;
                end else if (byte_received) begin
                    sh_addr_d    = rcv_byte[6:0];
                    sh_endp_d[0] = rcv_byte[7];
                    state_d      = ST_TOK2;
                end
            end

            ST_TOK2: begin
                // Bits [7:3] carry the CRC5, which the external checker verifies.
                if (eop) begin
                    abort_pkt = 1'b1;
                end else if (byte_received) begin
                    sh_endp_d[3:1] = rcv_byte[2:0];
                    state_d        = ST_WAIT_EOP;
                end
            end

            ST_DATA: begin
                if (eop) begin
                    abort_pkt = 1'b1;
                end else if (byte_received) begin
                    for (int k = 0; k < DATA_BYTES; k++) begin
                        if (cnt_q == CNT_W'(k)) payload_d[8*k +: 8] = rcv_byte;
                    end
                    if (cnt_q == LAST_IDX) state_d = ST_WAIT_EOP;
                    else                   cnt_d   = cnt_q + CNT_W'(1);
                end
            end

            ST_HS: begin
                // Handshakes have no body: the eop itself completes the packet.
                if (eop) begin
                    state_d     = ST_IDLE;
                    rcving_d    = 1'b0;
                    ack_valid_d = 1'b1;
                end else if (byte_received) begin
                    enter_err = 1'b1;
                end
            end

            ST_WAIT_EOP: begin
                if (eop) begin
                    if (pkt_q == PKT_TOKEN) begin
                        if (crc5_ok) begin
                            state_d       = ST_IDLE;
                            rcving_d      = 1'b0;
                            token_addr_d  = sh_addr_q;
                            token_endp_d  = sh_endp_q;
                            token_valid_d = 1'b1;
                            tok_seen_d    = 1'b1;
                        end else begin
                            abort_pkt = 1'b1;
                        end
                    end else begin
                        // Data is only accepted when it follows a good token.
                        if (crc16_ok && tok_seen_q) begin
                            state_d      = ST_IDLE;
                            rcving_d     = 1'b0;
                            rx_data_d    = payload_q;
                            data_valid_d = 1'b1;
                            tok_seen_d   = 1'b0;
                        end else begin
                            abort_pkt = 1'b1;
                        end
                    end
                end else if (byte_received) begin
                    enter_err = 1'b1;
                end
            end

            ST_ERR: begin
                if (eop) begin
                    state_d  = ST_IDLE;
                    rcving_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort_pkt) begin
            state_d     = ST_IDLE;
            rcving_d    = 1'b0;
            rcv_error_d = 1'b1;
            tok_seen_d  = 1'b0;
        end

        if (enter_err) begin
            state_d     = ST_ERR;
            rcv_error_d = 1'b1;
            tok_seen_d  = 1'b0;
        end
    end

    // Control state and visible outputs, synchronously reset
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge value of every other flop.
        if (rst) begin
            state_q       <= ST_IDLE;
            pkt_q         <= PKT_TOKEN;
            cnt_q         <= '0;
            tok_seen_q    <= 1'b0;
            crc_clear_q   <= 1'b0;
            rcving_q      <= 1'b0;
            token_valid_q <= 1'b0;
            token_addr_q  <= '0;
            token_endp_q  <= '0;
            data_valid_q  <= 1'b0;
            rx_data_q     <= '0;
            ack_valid_q   <= 1'b0;
            rcv_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pkt_q         <= pkt_d;
            cnt_q         <= cnt_d;
            tok_seen_q    <= tok_seen_d;
            crc_clear_q   <= crc_clear_d;
            rcving_q      <= rcving_d;
            token_valid_q <= token_valid_d;
            token_addr_q  <= token_addr_d;
            token_endp_q  <= token_endp_d;
            data_valid_q  <= data_valid_d;
            rx_data_q     <= rx_data_d;
            ack_valid_q   <= ack_valid_d;
            rcv_error_q   <= rcv_error_d;
        end
    end

    // Shadow capture registers
    always_ff @(posedge clk) begin
        // NOTE: shadows are left unreset on purpose; each is fully rewritten by a packet before it can be published.
        sh_addr_q <= sh_addr_d;
        sh_endp_q <= sh_endp_d;
        payload_q <= payload_d;
    end

    assign crc_clear   = crc_clear_q;
    assign rcving      = rcving_q;
    assign token_valid = token_valid_q;
    assign token_addr  = token_addr_q;
    assign token_endp  = token_endp_q;
    assign data_valid  = data_valid_q;
    assign rx_data     = rx_data_q;
    assign ack_valid   = ack_valid_q;
    assign rcv_error   = rcv_error_q;

endmodule
